// File: rtl/gigatron_ram_arbiter.sv
// Gigatron RAM arbiter: the CPU owns the RAM ports, and the host port borrows idle
// CPU slots. A host access that has waited MAX_WAIT cycles takes one slot by force
// and stalls the CPU for that single cycle. RAM read data arrives one cycle after its address.
module gigatron_ram_arbiter #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_raddr,
    input  logic        i_cpu_ren,
    input  logic [15:0] i_cpu_waddr,
    input  logic        i_cpu_we,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [15:0] i_host_addr,
    input  logic [7:0]  i_host_wdata,
    output logic        o_host_ack,
    output logic [7:0]  o_host_rdata,
    output logic [15:0] o_ram_raddr,
    output logic [15:0] o_ram_waddr,
    output logic        o_ram_we,
    output logic [7:0]  o_ram_wdata,
    input  logic [7:0]  i_ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             cmd_we_q;
    logic [15:0]      cmd_addr_q;
    logic [7:0]       cmd_wdata_q;
    logic             ack_q;
    logic [7:0]       host_rdata_q;

    logic slot_free_s;
    logic force_s;
    logic issue_s;
    logic host_wr_s;
    logic host_rd_s;

    // Decide whether the pending host access takes its RAM port in this cycle.
    always_comb begin
        slot_free_s = 1'b0;
        force_s     = 1'b0;
        if (state_q == ST_PEND) begin
            if (cmd_we_q) begin
                slot_free_s = ~i_cpu_we;
            end else begin
                slot_free_s = ~i_cpu_ren;
            end
            force_s = (wait_cnt_q == WAIT_LIMIT);
        end else begin
            slot_free_s = 1'b0;
            force_s     = 1'b0;
        end
        issue_s   = slot_free_s | force_s;
        host_wr_s = issue_s & cmd_we_q;
        host_rd_s = issue_s & ~cmd_we_q;
    end

    // Route each RAM port to the host only while it issues on that port; the other port stays with the CPU.
    always_comb begin
        o_ram_waddr = i_cpu_waddr;
        o_ram_we    = i_cpu_we;
        o_ram_wdata = i_cpu_wdata;
        o_ram_raddr = i_cpu_raddr;
        if (host_wr_s) begin
            o_ram_waddr = cmd_addr_q;
            o_ram_we    = 1'b1;
            o_ram_wdata = cmd_wdata_q;
        end else begin
            o_ram_waddr = i_cpu_waddr;
            o_ram_we    = i_cpu_we;
            o_ram_wdata = i_cpu_wdata;
        end
        if (host_rd_s) begin
            o_ram_raddr = cmd_addr_q;
        end else begin
            o_ram_raddr = i_cpu_raddr;
        end
        // The CPU is stalled only when the host takes a slot the CPU was using.
        o_cpu_stall = force_s & ~slot_free_s;
    end

    assign o_cpu_rdata  = i_ram_rdata;
    assign o_host_ack   = ack_q;
    assign o_host_rdata = host_rdata_q;

    // Host transaction FSM: capture, wait for a slot, collect read data, pulse ack.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= 16'h0000;
            cmd_wdata_q  <= 8'h00;
            ack_q        <= 1'b0;
            host_rdata_q <= 8'h00;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The ack cycle itself never captures, so a req still high from the
                    // finished transaction only starts a new one in the cycle after ack.
                    if (i_host_req && !ack_q) begin
                        cmd_we_q    <= i_host_we;
                        cmd_addr_q  <= i_host_addr;
                        cmd_wdata_q <= i_host_wdata;
                        wait_cnt_q  <= '0;
                        state_q     <= ST_PEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    if (issue_s) begin
                        state_q <= cmd_we_q ? ST_DONE : ST_RD;
                    end else begin
                        state_q <= ST_PEND;
                        if (wait_cnt_q != WAIT_LIMIT) begin
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    host_rdata_q <= i_ram_rdata;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    ack_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
